// File: rtl/mo_pkg.sv
// Shared motion-object types and defaults used by the object engine, line buffer and mixer.
package mo_pkg;

  localparam int unsigned MO_LINE_W = 256;
  localparam int unsigned MO_PIX_W  = 4;

  typedef logic [MO_PIX_W-1:0] mo_pix_t;

  localparam mo_pix_t MO_TRANSP = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } mo_scan_st_e;

endpackage

// File: rtl/mo_lb_bank.sv
// One DEPTH x W line-buffer bank: combinational read (registered by the caller),
// a draw write port and an erase port that restores the transparent value.
module mo_lb_bank
  import mo_pkg::*;
#(
  parameter int unsigned  DEPTH = MO_LINE_W,
  parameter int unsigned  W     = MO_PIX_W,
  parameter int unsigned  AW    = $clog2(DEPTH),
  parameter logic [W-1:0] ERASE = '1
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_c_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          er_en_i,
  input  logic [AW-1:0] er_addr_i
);

  logic [W-1:0] mem_q [DEPTH];

  assign rd_data_c_o = mem_q[rd_addr_i];

  // Erase is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (er_en_i) mem_q[er_addr_i] <= ERASE;
  end

endmodule

// File: rtl/mo_line_buffer.sv
// Double-buffered motion-object line buffer: one bank is drawn (first-wins RMW) while the
// other scans out and erases behind itself. MOB_HFLIP_EN adds a right-to-left scan option.
module mo_line_buffer
  import mo_pkg::*;
#(
  parameter int unsigned      LINE_W = MO_LINE_W,
  parameter int unsigned      PIX_W  = MO_PIX_W,
  parameter logic [PIX_W-1:0] TRANSP = '1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line_sync,
  input  logic                      wr_en,
  input  logic [$clog2(LINE_W)-1:0] wr_x,
  input  logic [PIX_W-1:0]          wr_pix,
  input  logic                      rd_ce,
  output logic [PIX_W-1:0]          rd_pix,
  output logic                      rd_valid,
  output logic                      rd_done,
  output logic                      bank_sel
`ifdef MOB_HFLIP_EN
  ,
  input  logic                      hflip
`endif
);

  localparam int unsigned   AW   = $clog2(LINE_W);
  localparam logic [AW-1:0] LAST = AW'(LINE_W - 1);

  mo_scan_st_e      state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [PIX_W-1:0] rd_pix_q, rd_pix_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_done_q, rd_done_d;
  logic             bank_sel_q, bank_sel_d;
  logic             p_vld_q, p_vld_d;
  logic             p_bank_q, p_bank_d;
  logic [AW-1:0]    p_x_q, p_x_d;
  logic [PIX_W-1:0] p_pix_q, p_pix_d;
  logic [PIX_W-1:0] p_old_q, p_old_d;

  logic [PIX_W-1:0] rdata_c [2];
  logic             scan_bank_c, scan_acc_c, scan_end_c, wr_ok_c, p_store_c;
  logic             scan_desc_c, sync_desc_c;

`ifdef MOB_HFLIP_EN
  logic desc_q;

  // Scan direction is latched once per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         desc_q <= 1'b0;
    else if (line_sync) desc_q <= hflip;
  end

  assign scan_desc_c = desc_q;
  assign sync_desc_c = hflip;
`else
  assign scan_desc_c = 1'b0;
  assign sync_desc_c = 1'b0;
`endif

  assign scan_bank_c = ~bank_sel_q;
  assign scan_acc_c  = rd_ce && !line_sync && (state_q == ST_SCAN);
  assign scan_end_c  = scan_desc_c ? (ptr_q == '0) : (ptr_q == LAST);
  assign wr_ok_c     = wr_en && (32'(wr_x) < LINE_W) && (wr_pix != TRANSP);
  assign p_store_c   = p_vld_q && (p_old_q == TRANSP);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_pix_d   = rd_pix_q;
    rd_valid_d = 1'b0;
    rd_done_d  = rd_done_q;
    bank_sel_d = bank_sel_q;
    if (line_sync) begin
      bank_sel_d = ~bank_sel_q;
      state_d    = ST_SCAN;
      ptr_d      = sync_desc_c ? LAST : '0;
      rd_done_d  = 1'b0;
      rd_pix_d   = TRANSP;
    end else if (rd_ce) begin
      if (state_q == ST_SCAN) begin
        rd_pix_d   = rdata_c[scan_bank_c];
        rd_valid_d = 1'b1;
        if (scan_end_c) begin
          state_d   = ST_IDLE;
          rd_done_d = 1'b1;
        end else begin
          ptr_d = scan_desc_c ? (ptr_q - AW'(1)) : (ptr_q + AW'(1));
        end
      end else begin
        rd_pix_d = TRANSP;
      end
    end
    // Draw RMW: read this cycle, store next cycle if the slot is still empty.
    p_vld_d  = wr_ok_c;
    p_x_d    = wr_x;
    p_pix_d  = wr_pix;
    p_bank_d = bank_sel_q;
    p_old_d  = rdata_c[bank_sel_q];
    if (p_store_c && (p_x_q == wr_x) && (p_bank_q == bank_sel_q)) p_old_d = p_pix_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rd_pix_q   <= TRANSP;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b1;
      bank_sel_q <= 1'b0;
      p_vld_q    <= 1'b0;
      p_bank_q   <= 1'b0;
      p_x_q      <= '0;
      p_pix_q    <= TRANSP;
      p_old_q    <= TRANSP;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_pix_q   <= rd_pix_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      bank_sel_q <= bank_sel_d;
      p_vld_q    <= p_vld_d;
      p_bank_q   <= p_bank_d;
      p_x_q      <= p_x_d;
      p_pix_q    <= p_pix_d;
      p_old_q    <= p_old_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BID = 1'(b);
    logic is_scan_c;
    assign is_scan_c = (scan_bank_c == BID);

    mo_lb_bank #(
      .DEPTH (LINE_W),
      .W     (PIX_W),
      .AW    (AW),
      .ERASE (TRANSP)
    ) u_bank (
      .clk         (clk),
      .rd_addr_i   (is_scan_c ? ptr_q : wr_x),
      .rd_data_c_o (rdata_c[b]),
      .wr_en_i     (p_store_c && (p_bank_q == BID)),
      .wr_addr_i   (p_x_q),
      .wr_data_i   (p_pix_q),
      .er_en_i     (scan_acc_c && is_scan_c),
      .er_addr_i   (ptr_q)
    );
  end

  assign rd_pix   = rd_pix_q;
  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign bank_sel = bank_sel_q;

endmodule

// File: tb/tb_mo_line_buffer.sv
// Directed bench for mo_line_buffer: a 256-wide and a 200-wide instance share the stimulus.
module tb_mo_line_buffer;

  localparam logic [3:0] TR = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_sync, wr_en, rd_ce;
  logic [7:0] wr_x;
  logic [3:0] wr_pix;
  logic [3:0] rd_pix, np_rd_pix;
  logic       rd_valid, rd_done, bank_sel;
  logic       np_rd_valid, np_rd_done, np_bank_sel;
`ifdef MOB_HFLIP_EN
  logic       hflip;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mo_line_buffer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_sync (line_sync),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_pix    (wr_pix),
    .rd_ce     (rd_ce),
    .rd_pix    (rd_pix),
    .rd_valid  (rd_valid),
    .rd_done   (rd_done),
    .bank_sel  (bank_sel)
`ifdef MOB_HFLIP_EN
    ,
    .hflip     (hflip)
`endif
  );

  mo_line_buffer #(.LINE_W(200)) u_np (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_sync (line_sync),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_pix    (wr_pix),
    .rd_ce     (rd_ce),
    .rd_pix    (np_rd_pix),
    .rd_valid  (np_rd_valid),
    .rd_done   (np_rd_done),
    .bank_sel  (np_bank_sel)
`ifdef MOB_HFLIP_EN
    ,
    .hflip     (hflip)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    line_sync = 1'b1;
    cyc();
    line_sync = 1'b0;
  endtask

  task automatic wr(input logic [7:0] x, input logic [3:0] p);
    wr_en  = 1'b1;
    wr_x   = x;
    wr_pix = p;
    cyc();
    wr_en  = 1'b0;
  endtask

  // 256 back-to-back rd_ce; ex_x is the only non-transparent x (-1 for none).
  task automatic scan_line(input string tag, input int ex_x, input logic [3:0] ex_p,
                           input bit chk_pix, input bit desc);
    int         bad, np_bad, x;
    logic [3:0] e;
    bad    = 0;
    np_bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd_ce = 1'b1;
      cyc();
      x = desc ? 255 - i : i;
      e = (x == ex_x) ? ex_p : TR;
      if (rd_valid !== 1'b1 || (chk_pix && rd_pix !== e)) bad++;
      if (i < 200) begin
        x = desc ? 199 - i : i;
        e = (x == ex_x) ? ex_p : TR;
        if (np_rd_valid !== 1'b1 || (chk_pix && np_rd_pix !== e)) np_bad++;
      end else if (np_rd_valid !== 1'b0 || np_rd_pix !== TR) begin
        np_bad++;
      end
      if (i == 254) chk({tag, "_done_early"}, 32'(rd_done), 32'(0));
      if (i == 198) chk({tag, "_np_done_early"}, 32'(np_rd_done), 32'(0));
      if (i == 199) chk({tag, "_np_done"}, 32'(np_rd_done), 32'(1));
    end
    rd_ce = 1'b0;
    chk({tag, "_done"}, 32'(rd_done), 32'(1));
    chk({tag, "_pix_errs"}, 32'(bad), 32'(0));
    chk({tag, "_np_pix_errs"}, 32'(np_bad), 32'(0));
    cyc();
    chk({tag, "_valid_fall"}, 32'(rd_valid), 32'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    line_sync = 1'b0;
    wr_en     = 1'b0;
    rd_ce     = 1'b0;
    wr_x      = '0;
    wr_pix    = '0;
`ifdef MOB_HFLIP_EN
    hflip     = 1'b0;
`endif
    cyc();
    cyc();
    chk("rst_pix", 32'(rd_pix), 32'(TR));
    chk("rst_valid", 32'(rd_valid), 32'(0));
    chk("rst_done", 32'(rd_done), 32'(1));
    chk("rst_bank", 32'(bank_sel), 32'(0));
    rst_n = 1'b1;
    cyc();
    rd_ce = 1'b1;
    cyc();
    rd_ce = 1'b0;
    chk("idle_ce_pix", 32'(rd_pix), 32'(TR));
    chk("idle_ce_valid", 32'(rd_valid), 32'(0));

    // Two flush lines clear the power-up contents of both banks.
    sync();
    chk("sync1_bank", 32'(bank_sel), 32'(1));
    chk("sync1_done", 32'(rd_done), 32'(0));
    chk("sync1_valid", 32'(rd_valid), 32'(0));
    scan_line("flush0", -1, TR, 1'b0, 1'b0);
    sync();
    chk("sync2_bank", 32'(bank_sel), 32'(0));
    scan_line("flush1", -1, TR, 1'b0, 1'b0);
    sync();
    chk("sync3_bank", 32'(bank_sel), 32'(1));
    scan_line("t1_transp", -1, TR, 1'b1, 1'b0);

    // Single pixel, then erase-behind check two lines later.
    wr(8'd10, 4'd3);
    cyc();
    sync();
    chk("t2_bank", 32'(bank_sel), 32'(0));
    scan_line("t2_x10", 10, 4'd3, 1'b1, 1'b0);
    sync();
    scan_line("t2_other", -1, TR, 1'b1, 1'b0);
    sync();
    scan_line("t2_erased", -1, TR, 1'b1, 1'b0);

    // Back-to-back writes to one x: first wins.
    wr(8'd20, 4'd5);
    wr(8'd20, 4'd2);
    cyc();
    sync();
    scan_line("t3_first_wins", 20, 4'd5, 1'b1, 1'b0);

    // Transparent write dropped; x=255 is the last slot of 256 and out of range for 200.
    wr(8'd5, TR);
    wr(8'd255, 4'd6);
    cyc();
    sync();
    scan_line("t4_range", 255, 4'd6, 1'b1, 1'b0);

    // Write and rd_ce coincident with line_sync.
    line_sync = 1'b1;
    rd_ce     = 1'b1;
    wr_en     = 1'b1;
    wr_x      = 8'd7;
    wr_pix    = 4'd1;
    cyc();
    line_sync = 1'b0;
    wr_en     = 1'b0;
    chk("t5_sync_valid", 32'(rd_valid), 32'(0));
    chk("t5_sync_bank", 32'(bank_sel), 32'(1));
    scan_line("t5_x7", 7, 4'd1, 1'b1, 1'b0);
    sync();
    scan_line("t5_not_next", -1, TR, 1'b1, 1'b0);

    // Asynchronous reset mid-line with a draw RMW in flight.
    sync();
    rd_ce = 1'b1;
    repeat (50) cyc();
    chk("mid_valid", 32'(rd_valid), 32'(1));
    wr(8'd30, 4'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pix", 32'(rd_pix), 32'(TR));
    chk("mid_rst_valid", 32'(rd_valid), 32'(0));
    chk("mid_rst_done", 32'(rd_done), 32'(1));
    chk("mid_rst_bank", 32'(bank_sel), 32'(0));
    chk("mid_rst_np_bank", 32'(np_bank_sel), 32'(0));
    rd_ce = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    sync();
    scan_line("rst_line0", -1, TR, 1'b1, 1'b0);
    sync();
    scan_line("rst_discard", -1, TR, 1'b1, 1'b0);

`ifdef MOB_HFLIP_EN
    // Descending scan: x=0 is the last pixel out.
    wr(8'd0, 4'd4);
    cyc();
    hflip = 1'b1;
    sync();
    hflip = 1'b0;
    scan_line("hflip_x0_last", 0, 4'd4, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
